// File: rtl/dcache_l2req_arb_pkg.sv
// Shared types for the dcache L1->L2 request arbiter: request field types,
// the grouped request-field struct and the round-robin side encoding.
package dcache_l2req_arb_pkg;

  localparam int NIDS_DEF = 16;
  localparam int IDW_DEF  = 5;

  typedef logic [IDW_DEF-1:0] l1_reqid_t;
  typedef logic [2:0]         sc_cmd_t;
  typedef logic [12:0]        sc_pcsign_t;
  typedef logic [11:0]        sc_poffset_t;
  typedef logic [2:0]         sc_ppaddr_t;

  // Everything a miss path hands to L2 apart from the allocated id.
  typedef struct packed {
    sc_cmd_t     cmd;
    sc_pcsign_t  pcsign;
    sc_poffset_t poffset;
    sc_ppaddr_t  ppaddr;
  } dc_l2req_fields_t;

  // Which requester wins the next tie.
  typedef enum logic {
    RR_LD = 1'b0,
    RR_ST = 1'b1
  } rr_side_e;

endpackage

// File: rtl/dcache_id_pool.sv
// L1 request-id pool: free bitmap, lowest-free allocation, outstanding counter.
// An id freed in one cycle becomes allocatable in the next, because allocation
// looks only at the registered bitmap.
module dcache_id_pool #(
  parameter int NIDS = 16,
  parameter int IDW  = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           alloc,
  input  logic           free_valid,
  input  logic [IDW-1:0] free_l1id,
  output logic [IDW-1:0] alloc_id,
  output logic           empty,
  output logic [IDW:0]   outstanding
);

  logic [NIDS-1:0] bitmap_q;
  logic [NIDS-1:0] bitmap_d;
  logic [NIDS-1:0] alloc_oh;
  logic [NIDS-1:0] free_oh;
  logic            alloc_ok;
  logic            free_ok;
  logic [IDW:0]    outstanding_q;

  assign empty       = (bitmap_q == '0);
  assign alloc_ok    = alloc && !empty;
  assign outstanding = outstanding_q;

  // Lowest free id: isolate the least significant set bit, then encode it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alloc_id = '0;
    alloc_oh = bitmap_q & (~bitmap_q + NIDS'(1));
    for (int i = 0; i < NIDS; i++) begin
      if (alloc_oh[i]) alloc_id = IDW'(i);
    end
  end

  // Decode the retire request; ids out of range or already free are dropped.
  always_comb begin
    free_oh = '0;
    for (int i = 0; i < NIDS; i++) begin
      free_oh[i] = free_valid && (free_l1id == IDW'(i));
    end
    free_ok = |(free_oh & ~bitmap_q);
  end

  // Next bitmap: clear the allocated bit, set the retired bit (never the same id).
  always_comb begin
    bitmap_d = bitmap_q;
    if (alloc_ok) bitmap_d = bitmap_d & ~alloc_oh;
    if (free_ok)  bitmap_d = bitmap_d | free_oh;
  end

  // Bitmap and outstanding counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      bitmap_q      <= '1;
      outstanding_q <= '0;
    end else begin
      bitmap_q      <= bitmap_d;
      outstanding_q <= outstanding_q + (IDW+1)'(alloc_ok) - (IDW+1)'(free_ok);
    end
  end

endmodule

// File: rtl/dcache_l2req_arb.sv
// Arbitrates the dcache load-miss and store-miss paths onto the single
// L1->L2 request channel, tagging each request with an L1 request id.
// Optional statistics counters are enabled with DCACHE_L2REQ_STATS_EN.
module dcache_l2req_arb
  import dcache_l2req_arb_pkg::*;
#(
  parameter int NIDS = 16,
  parameter int IDW  = 5
) (
  input  logic           clk,
  input  logic           reset,

  input  logic           ldmiss_valid,
  output logic           ldmiss_retry,
  input  logic [2:0]     ldmiss_cmd,
  input  logic [12:0]    ldmiss_pcsign,
  input  logic [11:0]    ldmiss_poffset,
  input  logic [2:0]     ldmiss_ppaddr,
  output logic [IDW-1:0] ldmiss_l1id,

  input  logic           stmiss_valid,
  output logic           stmiss_retry,
  input  logic [2:0]     stmiss_cmd,
  input  logic [12:0]    stmiss_pcsign,
  input  logic [11:0]    stmiss_poffset,
  input  logic [2:0]     stmiss_ppaddr,
  output logic [IDW-1:0] stmiss_l1id,

  output logic           l1tol2_req_valid,
  input  logic           l1tol2_req_retry,
  output logic [IDW-1:0] l1tol2_req_l1id,
  output logic [2:0]     l1tol2_req_cmd,
  output logic [12:0]    l1tol2_req_pcsign,
  output logic [11:0]    l1tol2_req_poffset,
  output logic [2:0]     l1tol2_req_ppaddr,

  input  logic           free_valid,
  input  logic [IDW-1:0] free_l1id,
  output logic [IDW:0]   ids_outstanding,
  output logic           ids_empty
`ifdef DCACHE_L2REQ_STATS_EN
  ,
  output logic [15:0]    stat_noid_cycles,
  output logic [15:0]    stat_l2stall_cycles
`endif
);

  dc_l2req_fields_t ld_fields;
  dc_l2req_fields_t st_fields;
  dc_l2req_fields_t oreg_fields;
  logic             oreg_valid;
  logic [IDW-1:0]   oreg_id;
  logic             oreg_free;
  logic             can_alloc;
  logic             ld_gnt;
  logic             st_gnt;
  logic [IDW-1:0]   alloc_id;
  rr_side_e         rr_q;
  rr_side_e         rr_d;

  assign ld_fields = '{cmd: ldmiss_cmd, pcsign: ldmiss_pcsign,
                       poffset: ldmiss_poffset, ppaddr: ldmiss_ppaddr};
  assign st_fields = '{cmd: stmiss_cmd, pcsign: stmiss_pcsign,
                       poffset: stmiss_poffset, ppaddr: stmiss_ppaddr};

  // The slot can take a new request if empty or draining this cycle.
  assign oreg_free = !oreg_valid || !l1tol2_req_retry;
  assign can_alloc = oreg_free && !ids_empty;

  dcache_id_pool #(
    .NIDS (NIDS),
    .IDW  (IDW)
  ) u_id_pool (
    .clk         (clk),
    .reset       (reset),
    .alloc       (ld_gnt || st_gnt),
    .free_valid  (free_valid),
    .free_l1id   (free_l1id),
    .alloc_id    (alloc_id),
    .empty       (ids_empty),
    .outstanding (ids_outstanding)
  );

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) rr_q <= RR_LD;
    else       rr_q <= rr_d;
  end

  // Grant selection, per-side retry and id echo; the pointer flips only on a tie.
  always_comb begin
    ld_gnt = 1'b0;
    st_gnt = 1'b0;
    rr_d   = rr_q;
    if (!reset && can_alloc) begin
      if (ldmiss_valid && stmiss_valid) begin
        if (rr_q == RR_LD) ld_gnt = 1'b1;
        else               st_gnt = 1'b1;
        rr_d = (rr_q == RR_LD) ? RR_ST : RR_LD;
      end else begin
        ld_gnt = ldmiss_valid;
        st_gnt = stmiss_valid;
      end
    end
    ldmiss_retry = !reset && ldmiss_valid && !ld_gnt;
    stmiss_retry = !reset && stmiss_valid && !st_gnt;
    ldmiss_l1id  = ld_gnt ? alloc_id : '0;
    stmiss_l1id  = st_gnt ? alloc_id : '0;
  end

  // Output slot: load on grant, hold while L2 retries, empty after a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      oreg_valid  <= 1'b0;
      oreg_id     <= '0;
      oreg_fields <= '0;
    end else if (ld_gnt || st_gnt) begin
      oreg_valid  <= 1'b1;
      oreg_id     <= alloc_id;
      oreg_fields <= ld_gnt ? ld_fields : st_fields;
    end else if (oreg_valid && !l1tol2_req_retry) begin
      oreg_valid  <= 1'b0;
    end
  end

  assign l1tol2_req_valid   = oreg_valid;
  assign l1tol2_req_l1id    = oreg_id;
  assign l1tol2_req_cmd     = oreg_fields.cmd;
  assign l1tol2_req_pcsign  = oreg_fields.pcsign;
  assign l1tol2_req_poffset = oreg_fields.poffset;
  assign l1tol2_req_ppaddr  = oreg_fields.ppaddr;

`ifdef DCACHE_L2REQ_STATS_EN
  // Saturating event counters: starved-of-ids cycles and L2 stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_noid_cycles    <= '0;
      stat_l2stall_cycles <= '0;
    end else begin
      if ((ldmiss_valid || stmiss_valid) && ids_empty && (stat_noid_cycles != '1))
        stat_noid_cycles <= stat_noid_cycles + 16'd1;
      if (l1tol2_req_valid && l1tol2_req_retry && (stat_l2stall_cycles != '1))
        stat_l2stall_cycles <= stat_l2stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_l2req_arb.sv
// Randomized scoreboard bench for dcache_l2req_arb. A reference model predicts
// grants and ids from the arbitration rules; granted requests are queued and a
// separate monitor compares them with what the DUT presents to L2.
module tb_dcache_l2req_arb;
  import dcache_l2req_arb_pkg::*;

  localparam int NIDS = 16;
  localparam int IDW  = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           ldmiss_valid, ldmiss_retry;
  logic [2:0]     ldmiss_cmd, ldmiss_ppaddr;
  logic [12:0]    ldmiss_pcsign;
  logic [11:0]    ldmiss_poffset;
  logic [IDW-1:0] ldmiss_l1id;
  logic           stmiss_valid, stmiss_retry;
  logic [2:0]     stmiss_cmd, stmiss_ppaddr;
  logic [12:0]    stmiss_pcsign;
  logic [11:0]    stmiss_poffset;
  logic [IDW-1:0] stmiss_l1id;
  logic           l1tol2_req_valid, l1tol2_req_retry;
  logic [IDW-1:0] l1tol2_req_l1id;
  logic [2:0]     l1tol2_req_cmd, l1tol2_req_ppaddr;
  logic [12:0]    l1tol2_req_pcsign;
  logic [11:0]    l1tol2_req_poffset;
  logic           free_valid;
  logic [IDW-1:0] free_l1id;
  logic [IDW:0]   ids_outstanding;
  logic           ids_empty;
`ifdef DCACHE_L2REQ_STATS_EN
  logic [15:0]    stat_noid_cycles, stat_l2stall_cycles;
`endif

  always #5 clk = ~clk;

  dcache_l2req_arb #(.NIDS(NIDS), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .ldmiss_valid(ldmiss_valid), .ldmiss_retry(ldmiss_retry), .ldmiss_cmd(ldmiss_cmd),
    .ldmiss_pcsign(ldmiss_pcsign), .ldmiss_poffset(ldmiss_poffset),
    .ldmiss_ppaddr(ldmiss_ppaddr), .ldmiss_l1id(ldmiss_l1id),
    .stmiss_valid(stmiss_valid), .stmiss_retry(stmiss_retry), .stmiss_cmd(stmiss_cmd),
    .stmiss_pcsign(stmiss_pcsign), .stmiss_poffset(stmiss_poffset),
    .stmiss_ppaddr(stmiss_ppaddr), .stmiss_l1id(stmiss_l1id),
    .l1tol2_req_valid(l1tol2_req_valid), .l1tol2_req_retry(l1tol2_req_retry),
    .l1tol2_req_l1id(l1tol2_req_l1id), .l1tol2_req_cmd(l1tol2_req_cmd),
    .l1tol2_req_pcsign(l1tol2_req_pcsign), .l1tol2_req_poffset(l1tol2_req_poffset),
    .l1tol2_req_ppaddr(l1tol2_req_ppaddr),
    .free_valid(free_valid), .free_l1id(free_l1id),
    .ids_outstanding(ids_outstanding), .ids_empty(ids_empty)
`ifdef DCACHE_L2REQ_STATS_EN
    , .stat_noid_cycles(stat_noid_cycles), .stat_l2stall_cycles(stat_l2stall_cycles)
`endif
  );

  typedef struct packed {
    logic [IDW-1:0]   id;
    dc_l2req_fields_t f;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: free id set, outstanding count, slot occupancy, tie owner.
  bit [NIDS-1:0]    m_free = '1;
  int               m_out  = 0;
  bit               m_occ  = 0;
  bit               m_st_next = 0;
  bit               ld_pend = 0, st_pend = 0;
  dc_l2req_fields_t ld_f, st_f;

  // Stimulus knobs in percent.
  int p_ld, p_st, p_retry, p_free, p_junk;
  bit rst_knob;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic dc_l2req_fields_t rand_fields();
    dc_l2req_fields_t f;
    f.cmd     = 3'($urandom);
    f.pcsign  = 13'($urandom);
    f.poffset = 12'($urandom);
    f.ppaddr  = 3'($urandom);
    return f;
  endfunction

  // Monitor: whatever the DUT presents to L2 must match the oldest expected request.
  always @(negedge clk) begin
    if (l1tol2_req_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL req_unexpected: got id 0x%0h expected no request at %0t",
                 l1tol2_req_l1id, $time);
      end else begin
        check("req_l1id", 32'(l1tol2_req_l1id), 32'(exp_q[0].id));
        check("req_fields", 32'({l1tol2_req_cmd, l1tol2_req_pcsign,
                                 l1tol2_req_poffset, l1tol2_req_ppaddr}), 32'(exp_q[0].f));
        if (l1tol2_req_retry === 1'b0) void'(exp_q.pop_front());
      end
    end
  end

  // Model one cycle: predict grants from the rules, check, then advance state.
  task automatic model_cycle();
    int  nfree  = $countones(m_free);
    int  lowest = -1;
    int  fidx   = int'(free_l1id);
    bit  can, ld_g, st_g, tie, free_ok;
    for (int i = NIDS - 1; i >= 0; i--) if (m_free[i]) lowest = i;
    can  = !reset && (!m_occ || !l1tol2_req_retry) && (nfree > 0);
    tie  = ld_pend && st_pend;
    ld_g = can && ld_pend && (!st_pend || !m_st_next);
    st_g = can && st_pend && (!ld_pend || m_st_next);

    check("ld_retry", 32'(ldmiss_retry), 32'(!reset && ld_pend && !ld_g));
    check("st_retry", 32'(stmiss_retry), 32'(!reset && st_pend && !st_g));
    if (ld_g) check("ld_l1id", 32'(ldmiss_l1id), 32'(lowest));
    if (st_g) check("st_l1id", 32'(stmiss_l1id), 32'(lowest));
    check("req_valid", 32'(l1tol2_req_valid), 32'(m_occ));
    check("ids_outstanding", 32'(ids_outstanding), 32'(m_out));
    check("ids_empty", 32'(ids_empty), 32'(nfree == 0));

    if (reset) begin
      m_free = '1; m_out = 0; m_occ = 0; m_st_next = 0;
      exp_q.delete();
    end else begin
      free_ok = free_valid && (fidx < NIDS) && !m_free[fidx];
      if (ld_g || st_g) begin
        exp_q.push_back('{id: IDW'(lowest), f: (ld_g ? ld_f : st_f)});
        m_free[lowest] = 1'b0;
        m_out++;
        m_occ = 1'b1;
        if (ld_g) ld_pend = 0; else st_pend = 0;
        if (tie) m_st_next = !m_st_next;
      end else if (!l1tol2_req_retry) begin
        m_occ = 1'b0;
      end
      if (free_ok) begin
        m_free[fidx] = 1'b1;
        m_out--;
      end
    end
  endtask

  // Drive one cycle of stimulus after the edge, then evaluate on the falling edge.
  task automatic step();
    int start;
    @(posedge clk); #1;
    if (!ld_pend && ($urandom_range(99) < p_ld)) begin ld_pend = 1; ld_f = rand_fields(); end
    if (!st_pend && ($urandom_range(99) < p_st)) begin st_pend = 1; st_f = rand_fields(); end
    ldmiss_valid = ld_pend;
    {ldmiss_cmd, ldmiss_pcsign, ldmiss_poffset, ldmiss_ppaddr} = ld_f;
    stmiss_valid = st_pend;
    {stmiss_cmd, stmiss_pcsign, stmiss_poffset, stmiss_ppaddr} = st_f;
    l1tol2_req_retry = ($urandom_range(99) < p_retry);
    reset = rst_knob;
    free_valid = ($urandom_range(99) < p_free);
    free_l1id  = IDW'($urandom_range(31));
    if (free_valid && ($urandom_range(99) >= p_junk)) begin
      start = $urandom_range(NIDS - 1);
      for (int k = 0; k < NIDS; k++) begin
        if (!m_free[(start + k) % NIDS]) begin
          free_l1id = IDW'((start + k) % NIDS);
          break;
        end
      end
    end
    @(negedge clk); #1;
    model_cycle();
  endtask

  task automatic phase(input int cycles, input int pl, input int ps, input int pr,
                       input int pf, input int pj);
    p_ld = pl; p_st = ps; p_retry = pr; p_free = pf; p_junk = pj;
    repeat (cycles) step();
  endtask

  initial begin
    reset = 1'b1;
    ldmiss_valid = 0; ldmiss_cmd = 0; ldmiss_pcsign = 0; ldmiss_poffset = 0; ldmiss_ppaddr = 0;
    stmiss_valid = 0; stmiss_cmd = 0; stmiss_pcsign = 0; stmiss_poffset = 0; stmiss_ppaddr = 0;
    l1tol2_req_retry = 0; free_valid = 0; free_l1id = 0;
    ld_f = '0; st_f = '0;
    repeat (2) @(posedge clk);

    rst_knob = 1'b1;
    phase(2, 0, 0, 0, 0, 0);
`ifdef DCACHE_L2REQ_STATS_EN
    check("stat_noid_reset", 32'(stat_noid_cycles), 32'd0);
    check("stat_l2stall_reset", 32'(stat_l2stall_cycles), 32'd0);
`endif
    rst_knob = 1'b0;

    phase(5,   100, 0,   0,   0,   0);    // load path alone
    phase(8,   100, 100, 0,   0,   0);    // contention, alternating grants
    phase(10,  100, 100, 80,  0,   0);    // L2 back-pressure with slot full
    phase(40,  100, 100, 0,   0,   0);    // run the pool dry and stay there
    phase(30,  100, 100, 10,  50,  30);   // refill, including stale/out-of-range frees
    phase(300, 60,  60,  30,  40,  20);   // general mix

    phase(4,   100, 100, 100, 0,   0);    // slot held by L2
    rst_knob = 1'b1;
    phase(1,   100, 100, 100, 0,   0);    // reset mid-transfer
`ifdef DCACHE_L2REQ_STATS_EN
    @(negedge clk);
    check("stat_noid_midreset", 32'(stat_noid_cycles), 32'd0);
    check("stat_l2stall_midreset", 32'(stat_l2stall_cycles), 32'd0);
`endif
    rst_knob = 1'b0;
    phase(200, 70,  70,  25,  45,  10);

    check("scoreboard_drain", 32'(exp_q.size()), 32'(m_occ));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
